traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
Passive checker on the receiving end of the 3-bit `light` bus driven by `traffic_light_controller`. It decodes the one-hot light code and tracks the expected sequence RED -> GREEN -> YELLOW -> RED. It measures the dwell time of each phase in clock cycles and raises sticky error flags for illegal codes, wrong order, and out-of-range dwell. It sits beside the controller in the top-level or bench and adds no load to the controller.

Parameters:
- RED_MIN, 5, minimum legal RED dwell (cycles)
- RED_MAX, 10, maximum legal RED dwell (cycles)
- GREEN_MIN, 5, minimum legal GREEN dwell
- GREEN_MAX, 10, maximum legal GREEN dwell
- YELLOW_MIN, 2, minimum legal YELLOW dwell
- YELLOW_MAX, 4, maximum legal YELLOW dwell
- TMR_W, 8, dwell timer width; every *_MAX must be < 2^TMR_W - 1
- CNT_W, 16, completed-cycle counter width

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- light  input  3  observed light code: [2]=RED, [1]=YELLOW, [0]=GREEN; legal values 100, 001, 010
- phase  output  2  current tracked phase: 0=NONE, 1=RED, 2=GREEN, 3=YELLOW
- locked  output  1  high while tracking a valid sequence
- err_illegal  output  1  sticky: a non-one-hot code (including 000) was sampled
- err_order  output  1  sticky: a legal code arrived out of sequence
- err_timing  output  1  sticky: a phase dwell fell below MIN or exceeded MAX
- cycle_count  output  CNT_W  number of legal YELLOW -> RED completions; saturates at all-ones

Behaviour:
- All outputs are registered. A decision on a `light` sample at edge k is visible immediately after edge k (1-clock latency from input to flag).
- Reset, applied at any time including mid-phase: phase=0, locked=0, all err_*=0, cycle_count=0, dwell=0, state=SYNC, first=1.
- FSM states: SYNC, RED, GREEN, YELLOW.
- SYNC:
  - Light 100 -> RED, dwell=1, locked=1.
  - Other legal codes are ignored; the FSM stays in SYNC.
  - Illegal code -> err_illegal=1; the FSM stays in SYNC.
- Tracking state P, same code sampled: dwell += 1, saturating at 2^TMR_W-1.
  - At the sample where dwell reaches P_MAX+1: err_timing=1, state -> SYNC, locked=0, phase=0.
- Tracking state P, successor code sampled (RED->GREEN, GREEN->YELLOW, YELLOW->RED):
  - If dwell < P_MIN and first==0: err_timing=1, state -> SYNC.
  - Otherwise enter the successor with dwell=1 and clear first.
  - YELLOW->RED with no error increments cycle_count.
- `first` is set on entry from SYNC. The first phase after SYNC is checked only against MAX, because its start was not observed.
- Tracking state P, non-successor legal code sampled: err_order=1, state -> SYNC.
- Tracking state P, illegal code sampled: err_illegal=1, state -> SYNC.
- Simultaneous events: all applicable err_* flags set on the same edge. Example: an illegal code arriving while dwell < MIN sets only err_illegal, because MIN is evaluated only on legal successor transitions.
- Err flags stay set until rst. After an error the monitor resynchronises on the next RED sample, and locked returns to 1.
- phase mirrors the FSM state: NONE in SYNC.

Decomposition:
- `traffic_light_pkg` holds:
  - light code constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001
  - phase encoding constants PH_NONE/PH_RED/PH_GREEN/PH_YELLOW
  - a next_phase function
- Sub-module `phase_dwell_timer`: TMR_W saturating counter with sync load-to-1 and increment enable. It is shared so the controller can reuse it.
- The FSM, checks and cycle counter live in the top module.

Test Plan:
- Nominal: after rst, drive 100x6, 001x6, 010x3, repeated 3 loops, then 100.
  - Required: locked=1 from the first RED sample; cycle_count=3; all err_*=0; phase steps 1,2,3.
- Order error: locked in RED for 6 cycles, then drive 010.
  - Required: err_order=1 and locked=0 on that edge; the next 100 sample restores locked=1 while err_order stays 1.
- Short dwell: complete a RED (6), then GREEN x3, then 010.
  - Required: err_timing=1 on the 010 sample; phase=0.
- Long dwell: complete a RED (6), then hold 001 for 11 samples.
  - Required: err_timing=1 on the 11th GREEN sample, not before.
- Illegal code: during GREEN drive 110 for 1 cycle, then 100.
  - Required: err_illegal=1; relock on 100; err_order=0; err_timing=0.
- Reset mid-operation: err_timing=1 and cycle_count=2, then assert rst for 1 cycle during YELLOW.
  - Required: all outputs 0 after the edge; the monitor waits in SYNC ignoring 010 until 100 arrives.

Source files
------------

// File: rtl/traffic_light_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_light_pkg                                           |
// | Purpose  : Shared light-code constants, phase encoding, FSM state type |
// |            and phase helper functions for the traffic light monitor.   |
// | Contents : LIGHT_* one-hot codes, PH_* phase codes, tl_state_e,        |
// |            next_phase(), light_to_phase()                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package traffic_light_pkg;

  // One-hot light codes: [2]=RED, [1]=YELLOW, [0]=GREEN
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Phase encoding as presented on the phase output
  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  // State codes deliberately equal the phase codes so phase mirrors state
  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } tl_state_e;

  // Legal successor of a phase; NONE has no successor
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_RED:    nxt = PH_GREEN;
      PH_GREEN:  nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      default:   nxt = PH_NONE;
    endcase
    return nxt;
  endfunction

  // Decode a light code; any non-one-hot code maps to NONE
  function automatic logic [1:0] light_to_phase(input logic [2:0] light);
    logic [1:0] ph;
    case (light)
      LIGHT_RED:    ph = PH_RED;
      LIGHT_GREEN:  ph = PH_GREEN;
      LIGHT_YELLOW: ph = PH_YELLOW;
      default:      ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_light_monitor_if                                    |
// | Purpose  : Groups the observed light bus and the monitor status.       |
// | Ports    : light (3), phase (2), locked, err_illegal, err_order,       |
// |            err_timing, cycle_count (CNT_W)                             |
// |            master - light source side / status consumer                |
// |            slave  - monitor side (observes light, drives status)       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface traffic_light_monitor_if #(
  parameter int CNT_W = 16
);

  logic [2:0]       light;
  logic [1:0]       phase;
  logic             locked;
  logic             err_illegal;
  logic             err_order;
  logic             err_timing;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output light,
    input  phase, locked, err_illegal, err_order, err_timing, cycle_count
  );

  modport slave (
    input  light,
    output phase, locked, err_illegal, err_order, err_timing, cycle_count
  );

endinterface
`default_nettype wire

// File: rtl/phase_dwell_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : phase_dwell_timer                                           |
// | Purpose  : Saturating dwell counter with synchronous load-to-1 and     |
// |            increment enable. Load has priority over increment.         |
// | Ports    : clk, rst     - clock, synchronous active-high reset         |
// |            load_i       - restart count at 1 (first cycle of a phase)  |
// |            inc_i        - add one, holding at all-ones                 |
// |            count_o      - current dwell count                          |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module phase_dwell_timer #(
  parameter int TMR_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic             inc_i,
  output logic [TMR_W-1:0]      count_o
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= TMR_W'(1);
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : traffic_light_monitor                                       |
// | Purpose  : Passive checker of the RED->GREEN->YELLOW->RED light bus.   |
// |            Tracks phase, measures dwell, raises sticky error flags     |
// |            and counts completed YELLOW->RED cycles.                    |
// | Ports    : clk, rst - clock, synchronous active-high reset            |
// |            bus      - slave modport: light in; phase, locked,          |
// |                       err_illegal, err_order, err_timing,              |
// |                       cycle_count out (all registered)                 |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_MIN    = 5,
  parameter int unsigned RED_MAX    = 10,
  parameter int unsigned GREEN_MIN  = 5,
  parameter int unsigned GREEN_MAX  = 10,
  parameter int unsigned YELLOW_MIN = 2,
  parameter int unsigned YELLOW_MAX = 4,
  parameter int          TMR_W      = 8,
  parameter int          CNT_W      = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  traffic_light_monitor_if.slave  bus
);

  tl_state_e        state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             first_q, first_d;
  logic             err_ill_q, err_ill_d;
  logic             err_ord_q, err_ord_d;
  logic             err_tim_q, err_tim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [TMR_W-1:0] w_dwell;
  logic             w_load;
  logic             w_inc;
  logic [1:0]       w_in_ph;
  logic [1:0]       w_cur_ph;
  logic [TMR_W-1:0] w_min;
  logic [TMR_W-1:0] w_max;

  phase_dwell_timer #(
    .TMR_W (TMR_W)
  ) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .inc_i   (w_inc),
    .count_o (w_dwell)
  );

  assign w_in_ph  = light_to_phase(bus.light);
  assign w_cur_ph = state_q;

  // Dwell limits of the phase currently being tracked
  always_comb begin
    w_min = '0;
    w_max = '0;
    case (state_q)
      ST_RED: begin
        w_min = TMR_W'(RED_MIN);
        w_max = TMR_W'(RED_MAX);
      end
      ST_GREEN: begin
        w_min = TMR_W'(GREEN_MIN);
        w_max = TMR_W'(GREEN_MAX);
      end
      ST_YELLOW: begin
        w_min = TMR_W'(YELLOW_MIN);
        w_max = TMR_W'(YELLOW_MAX);
      end
      default: ;
    endcase
  end

  // Next-state and check logic
  always_comb begin
    state_d   = state_q;
    locked_d  = locked_q;
    first_d   = first_q;
    err_ill_d = err_ill_q;
    err_ord_d = err_ord_q;
    err_tim_d = err_tim_q;
    cnt_d     = cnt_q;
    w_load    = 1'b0;
    w_inc     = 1'b0;

    if (state_q == ST_SYNC) begin
      if (w_in_ph == PH_NONE) begin
        err_ill_d = 1'b1;
      end else if (w_in_ph == PH_RED) begin
        // Start of this RED was not seen, so its MIN is not checked
        state_d  = ST_RED;
        locked_d = 1'b1;
        first_d  = 1'b1;
        w_load   = 1'b1;
      end
    end else begin
      if (w_in_ph == PH_NONE) begin
        err_ill_d = 1'b1;
        state_d   = ST_SYNC;
        locked_d  = 1'b0;
      end else if (w_in_ph == w_cur_ph) begin
        // This sample would make dwell MAX+1
        if (w_dwell >= w_max) begin
          err_tim_d = 1'b1;
          state_d   = ST_SYNC;
          locked_d  = 1'b0;
        end else begin
          w_inc = 1'b1;
        end
      end else if (w_in_ph == next_phase(w_cur_ph)) begin
        if ((w_dwell < w_min) && !first_q) begin
          err_tim_d = 1'b1;
          state_d   = ST_SYNC;
          locked_d  = 1'b0;
        end else begin
          state_d = tl_state_e'(w_in_ph);
          first_d = 1'b0;
          w_load  = 1'b1;
          if ((state_q == ST_YELLOW) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end else begin
        err_ord_d = 1'b1;
        state_d   = ST_SYNC;
        locked_d  = 1'b0;
      end
    end

    phase_d = state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_SYNC;
      phase_q   <= PH_NONE;
      locked_q  <= 1'b0;
      first_q   <= 1'b1;
      err_ill_q <= 1'b0;
      err_ord_q <= 1'b0;
      err_tim_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      locked_q  <= locked_d;
      first_q   <= first_d;
      err_ill_q <= err_ill_d;
      err_ord_q <= err_ord_d;
      err_tim_q <= err_tim_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.locked      = locked_q;
  assign bus.err_illegal = err_ill_q;
  assign bus.err_order   = err_ord_q;
  assign bus.err_timing  = err_tim_q;
  assign bus.cycle_count = cnt_q;

endmodule
`default_nettype wire
